// File: rtl/sync_fifo_ctrl_if.sv
// rtl/sync_fifo_ctrl_if.sv - handshake, status and RAM-port bundle for sync_fifo_ctrl
// master: controller side; slave: producer/consumer/RAM side.
interface sync_fifo_ctrl_if #(
    parameter int DATA = 16,
    parameter int ADDR = 5
);
    logic            in_valid;
    logic [DATA-1:0] in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic [ADDR:0]   level;
    logic            ovf;
    logic            ram_a_wr;
    logic [ADDR-1:0] ram_a_addr;
    logic [DATA-1:0] ram_a_wdata;
    logic [ADDR-1:0] ram_b_addr;
    logic [DATA-1:0] ram_b_rdata;

    modport master (
        input  in_valid, in_data, out_ready, ram_b_rdata,
        output in_ready, out_valid, out_data, level, ovf,
               ram_a_wr, ram_a_addr, ram_a_wdata, ram_b_addr
    );

    modport slave (
        output in_valid, in_data, out_ready, ram_b_rdata,
        input  in_ready, out_valid, out_data, level, ovf,
               ram_a_wr, ram_a_addr, ram_a_wdata, ram_b_addr
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - synchronous FIFO controller around an external dual-port RAM
// Port B has one cycle of read latency, so the read address runs one word ahead on a pop.
module sync_fifo_ctrl #(
    parameter int DATA = 16,
    parameter int ADDR = 5
) (
    input  logic             clK,
    input  logic             rst,
    sync_fifo_ctrl_if.master bus
);
    localparam int            LW    = ADDR + 1;
    localparam logic [ADDR:0] DEPTH = {1'b1, {ADDR{1'b0}}};

    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [ADDR:0]   r_level;
    logic            r_out_valid;
    logic            r_ovf;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [ADDR:0]   w_level_less_pop;
    logic [DATA-1:0] w_wdata;

    assign w_full           = (r_level == DEPTH);
    assign w_push           = bus.in_valid && !w_full;
    assign w_pop            = r_out_valid && bus.out_ready;
    assign w_level_less_pop = r_level - LW'(w_pop);
    assign w_wdata          = bus.in_data;

    assign bus.in_ready    = !w_full;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = bus.ram_b_rdata;
    assign bus.level       = r_level;
    assign bus.ovf         = r_ovf;
    assign bus.ram_a_wr    = w_push;
    assign bus.ram_a_addr  = r_wr_ptr;
    assign bus.ram_a_wdata = w_wdata;
    // Re-read the head while it is held so out_data stays put under backpressure.
    assign bus.ram_b_addr  = w_pop ? r_rd_ptr + ADDR'(1'b1) : r_rd_ptr;

    always_ff @(posedge clK) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR'(1'b1);
            end
            r_level <= w_level_less_pop + LW'(w_push);
            // A word written at this edge is not yet readable, so it must not raise out_valid.
            r_out_valid <= (w_level_less_pop != '0);
            if (bus.in_valid && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl with a queue reference model
module tb_sync_fifo_ctrl;
    localparam int DATA  = 16;
    localparam int ADDR  = 5;
    localparam int DEPTH = 32;

    logic clK = 1'b0;
    logic rst = 1'b1;
    always #5 clK = ~clK;

    sync_fifo_ctrl_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

    sync_fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clK (clK),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA-1:0] ram [DEPTH];
    always @(posedge clK) begin
        bus.ram_b_rdata <= ram[bus.ram_b_addr];
        if (bus.ram_a_wr) ram[bus.ram_a_addr] <= bus.ram_a_wdata;
    end

    int checks = 0;
    int errors = 0;
    bit live   = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: q holds words already written to RAM, oldest first.
    logic [DATA-1:0] q[$];
    logic [DATA-1:0] push_log[$];
    bit m_valid, m_ovf, m_do_push, m_do_pop;
    int m_stored;
    int unsigned m_wr, m_rd;

    always @(posedge clK) begin
        cyc++;
        if (rst) begin
            q.delete();
            m_valid = 0;
            m_ovf   = 0;
            m_wr    = 0;
            m_rd    = 0;
        end else begin
            m_stored  = q.size();
            m_do_push = bus.in_valid && (m_stored < DEPTH);
            m_do_pop  = m_valid && bus.out_ready;
            if (bus.in_valid && m_stored == DEPTH) m_ovf = 1;
            if (m_do_pop) begin
                void'(q.pop_front());
                m_rd++;
            end
            m_valid = (m_stored - int'(m_do_pop)) != 0;
            if (m_do_push) begin
                q.push_back(bus.in_data);
                push_log.push_back(bus.in_data);
                m_wr++;
            end
        end
    end

    logic [DATA-1:0] dut_out[$];
    int              dut_out_cyc[$];
    bit              hold_prev = 0;
    logic [DATA-1:0] hold_data;

    always @(negedge clK) begin
        if (live) begin
            chk("in_ready", bus.in_ready, q.size() < DEPTH);
            chk("level", bus.level, q.size());
            chk("out_valid", bus.out_valid, m_valid);
            chk("ovf", bus.ovf, m_ovf);
            chk("ram_a_wr", bus.ram_a_wr, bus.in_valid && (q.size() < DEPTH));
            if (bus.in_valid && q.size() < DEPTH) begin
                chk("ram_a_addr", bus.ram_a_addr, m_wr % DEPTH);
                chk("ram_a_wdata", bus.ram_a_wdata, bus.in_data);
            end
            chk("ram_b_addr", bus.ram_b_addr, (m_rd + (m_valid && bus.out_ready)) % DEPTH);
            if (m_valid) chk("out_data", bus.out_data, q[0]);
            if (hold_prev && bus.out_valid) chk("hold_stable", bus.out_data, hold_data);
            hold_prev = bus.out_valid && !bus.out_ready && !rst;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready && !rst) begin
                dut_out.push_back(bus.out_data);
                dut_out_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clK);
        #1;
    endtask

    initial begin
        bus.in_valid  = 0;
        bus.in_data   = '0;
        bus.out_ready = 0;
        tick();
        tick();
        rst  = 0;
        live = 1;
        chk("rst_level", bus.level, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_ovf", bus.ovf, 0);

        // single word
        bus.in_valid = 1;
        bus.in_data  = 16'hA5A5;
        tick();
        bus.in_valid = 0;
        chk("single_e0_valid", bus.out_valid, 0);
        chk("single_e0_level", bus.level, 1);
        tick();
        chk("single_e1_valid", bus.out_valid, 1);
        chk("single_e1_data", bus.out_data, 16'hA5A5);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("single_pop_level", bus.level, 0);
        chk("single_pop_valid", bus.out_valid, 0);

        // fill, overflow, full plus pop
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid = 1;
            bus.in_data  = DATA'($urandom);
            tick();
        end
        bus.in_valid = 0;
        chk("fill_level", bus.level, 32);
        chk("fill_in_ready", bus.in_ready, 0);
        chk("fill_ovf_clear", bus.ovf, 0);
        bus.in_valid = 1;
        tick();
        chk("fill_ovf_set", bus.ovf, 1);
        chk("fill_level_held", bus.level, 32);
        bus.out_ready = 1;
        tick();
        chk("fullpop_level", bus.level, 31);
        chk("fullpop_in_ready", bus.in_ready, 1);
        bus.out_ready = 0;
        tick();
        bus.in_valid = 0;
        chk("fullpop_refill", bus.level, 32);
        rst = 1;
        tick();
        rst = 0;
        chk("clr_level", bus.level, 0);
        chk("clr_ovf", bus.ovf, 0);

        // streaming 0..99
        dut_out.delete();
        dut_out_cyc.delete();
        bus.out_ready = 1;
        for (int v = 0; v < 100; v++) begin
            bus.in_valid = 1;
            bus.in_data  = DATA'(v);
            tick();
            if (v == 20 || v == 60) chk("stream_level", bus.level, 2);
        end
        bus.in_valid = 0;
        for (int k = 0; k < 10; k++) tick();
        chk("stream_count", dut_out.size(), 100);
        if (dut_out.size() == 100) begin
            for (int i = 0; i < 100; i++) chk("stream_order", dut_out[i], i);
            chk("stream_rate", dut_out_cyc[99] - dut_out_cyc[0], 99);
        end

        // random backpressure
        dut_out.delete();
        push_log.delete();
        for (int i = 0; i < 1000; i++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.in_data   = DATA'($urandom);
            bus.out_ready = $urandom_range(0, 1);
            tick();
        end
        bus.in_valid  = 0;
        bus.out_ready = 1;
        for (int k = 0; k < 40 && q.size() != 0; k++) tick();
        tick();
        chk("bp_drained", bus.level, 0);
        chk("bp_count", dut_out.size(), push_log.size());
        if (dut_out.size() == push_log.size()) begin
            for (int i = 0; i < push_log.size(); i++) chk("bp_data", dut_out[i], push_log[i]);
        end

        // reset mid-stream
        bus.out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1;
            bus.in_data  = DATA'($urandom);
            tick();
        end
        chk("mid_level", bus.level, 10);
        rst           = 1;
        bus.out_ready = 1;
        tick();
        rst           = 0;
        bus.in_valid  = 0;
        bus.out_ready = 0;
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1;
        bus.in_data  = 16'h1234;
        tick();
        bus.in_valid = 0;
        chk("mid_e0_valid", bus.out_valid, 0);
        tick();
        chk("mid_e1_valid", bus.out_valid, 1);
        chk("mid_e1_data", bus.out_data, 16'h1234);
        tick();

        live = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA, default 16, data word width in bits.
REQ-002 The block SHALL have parameter ADDR, default 5, RAM address width in bits; capacity is 2**ADDR words.
REQ-003 The block SHALL have port clK  input  1  the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  write request.
REQ-006 The block SHALL have port in_data  input  DATA  write word.
REQ-007 The block SHALL have port in_ready  output  1  room available, equal to !full.
REQ-008 The block SHALL have port out_valid  output  1  head word presented on out_data.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the head word.
REQ-010 The block SHALL have port out_data  output  DATA  head word, wired directly from ram_b_rdata.
REQ-011 The block SHALL have port level  output  ADDR+1  number of stored words, 0..2**ADDR.
REQ-012 The block SHALL have port ovf  output  1  sticky flag: a write was attempted while full.
REQ-013 The block SHALL have port ram_a_wr  output  1  RAM port A write enable.
REQ-014 The block SHALL have port ram_a_addr  output  ADDR  RAM port A address, equal to wr_ptr.
REQ-015 The block SHALL have port ram_a_wdata  output  DATA  RAM port A write data, equal to in_data.
REQ-016 The block SHALL have port ram_b_addr  output  ADDR  RAM port B read address.
REQ-017 The block SHALL have port ram_b_rdata  input  DATA  RAM port B registered read data (1-cycle latency, read-before-write); port B write enable SHALL be tied 0 by the integrator.

Function
REQ-018 The block SHALL define push = in_valid && !full and pop = out_valid && out_ready, where full = (level == 2**ADDR).
REQ-019 The block SHALL assert ram_a_wr = push in the same cycle and increment wr_ptr modulo 2**ADDR on every push.
REQ-020 The block SHALL drive ram_b_addr = rd_ptr + 1 (mod 2**ADDR) when pop is high, else rd_ptr, so the RAM re-reads the head whenever the head is not consumed.
REQ-021 The block SHALL increment rd_ptr modulo 2**ADDR on every pop.
REQ-022 The block SHALL update level <= level + push - pop on every edge; simultaneous push and pop SHALL leave level unchanged.
REQ-023 The block SHALL register out_valid <= ((level - pop) != 0); words pushed at the current edge SHALL NOT count, so out_valid never exposes data not yet written to RAM.
REQ-024 The block SHALL give first-word latency of 2 edges: a word pushed into an empty FIFO at edge E0 is issued for read in the next cycle and appears with out_valid=1 after edge E1.
REQ-025 The block SHALL sustain one push and one pop per cycle when neither full nor empty.
REQ-026 The block SHALL hold out_data stable while out_valid && !out_ready; the head slot is never written while occupied.
REQ-027 When full, in_ready SHALL be 0 even if pop is high in the same cycle; the word is accepted in a later cycle.
REQ-028 The block SHALL set ovf <= 1 on any edge with in_valid && full, and hold it until reset.
REQ-029 Pop with out_valid=0 SHALL be impossible by construction; out_ready while empty SHALL have no effect.
REQ-030 Pointers SHALL wrap silently from 2**ADDR-1 to 0 with no bubble.

Reset
REQ-031 While rst=1 at an edge, the block SHALL set wr_ptr=0, rd_ptr=0, level=0, out_valid=0, ovf=0; in_ready SHALL be 1 from the next cycle.
REQ-032 Reset mid-operation SHALL discard all stored words; RAM contents are not cleared, and out_data is don't-care while out_valid=0.
REQ-033 rst SHALL take priority over push and pop in the same cycle.

Verification
REQ-034 The bench SHALL cover single word: push 0xA5A5 into empty FIFO at E0 -> out_valid=1 with out_data=0xA5A5 after E1, level=1; pop -> level=0, out_valid=0.
REQ-035 The bench SHALL cover fill: ADDR=5, 32 pushes with out_ready=0 -> level=32, in_ready=0; 33rd in_valid -> not accepted, ovf=1.
REQ-036 The bench SHALL cover streaming: continuous push and pop of values 0..99 -> output order 0..99, one word per cycle after first-word latency, level constant.
REQ-037 The bench SHALL cover backpressure: out_ready toggled randomly for 1000 cycles -> out_data never changes while out_valid && !out_ready, and no word is lost or duplicated.
REQ-038 The bench SHALL cover full plus pop: full FIFO, pop and in_valid in the same cycle -> no push, level=31; next cycle push accepted -> level=32.
REQ-039 The bench SHALL cover reset mid-stream: rst at level=10 -> next cycle level=0, out_valid=0, ovf=0; first subsequent push returns its own data after E1.
